// File: rtl/alarm_sequencer.sv
// Keypad arm/disarm controller: assembles 4-digit codes, enforces wrong-code lockout,
// and sequences exit delay / armed / entry delay / alarm from the door and facility sensors.
module alarm_sequencer #(
  parameter logic [15:0] CODE           = 16'h0965,
  parameter int          EXIT_CYCLES    = 16,
  parameter int          ENTRY_CYCLES   = 16,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 32,
  parameter int          DIGIT_TIMEOUT  = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  output logic                               key_ready,
  input  logic                               door_movement_detected,
  input  logic                               facility_movement_detected,
  output logic [2:0]                         state,
  output logic                               armed,
  output logic                               led,
  output logic                               alert_authorities,
  output logic                               lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int DLY_MAX = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int DW = $clog2(DLY_MAX + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int IW = $clog2(DIGIT_TIMEOUT + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  localparam logic [DW-1:0] EXIT_LOAD  = DW'(EXIT_CYCLES);
  localparam logic [DW-1:0] ENTRY_LOAD = DW'(ENTRY_CYCLES);
  localparam logic [DW-1:0] DLY_ONE    = DW'(1);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCKOUT_CYCLES);
  localparam logic [LW-1:0] LOCK_ONE   = LW'(1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(DIGIT_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_ONE   = IW'(1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [FW-1:0] FAIL_ONE   = FW'(1);

  typedef enum logic [2:0] {
    S_DISARMED    = 3'd0,
    S_EXIT_DELAY  = 3'd1,
    S_ARMED       = 3'd2,
    S_ENTRY_DELAY = 3'd3,
    S_ALARM       = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [11:0]   digits_q, digits_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [FW-1:0] fail_inc;
  logic          lockout_q, lockout_d;
  logic [LW-1:0] lock_tmr_q, lock_tmr_d;
  logic          key_ready_q, key_ready_d;
  logic          armed_q, armed_d;
  logic          led_q, led_d;
  logic          alert_q, alert_d;

  logic          accept;
  logic          code_done;
  logic          code_ok;
  logic          code_bad;

  assign accept    = key_valid && key_ready_q;
  assign code_done = accept && (cnt_q == 2'd3);
  assign code_ok   = code_done && ({digits_q, key_code} == CODE);
  assign code_bad  = code_done && ({digits_q, key_code} != CODE);
  assign fail_inc  = fail_q + FAIL_ONE;

  // Digit assembly; a stalled partial entry is dropped without counting as a failure.
  always_comb begin
    digits_d = digits_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    if (accept) begin
      idle_d = '0;
      if (cnt_q == 2'd3) begin
        digits_d = '0;
        cnt_d    = '0;
      end else begin
        digits_d = {digits_q[7:0], key_code};
        cnt_d    = cnt_q + 2'd1;
      end
    end else if (cnt_q != 2'd0) begin
      if (idle_q == IDLE_LAST) begin
        digits_d = '0;
        cnt_d    = '0;
        idle_d   = '0;
      end else begin
        idle_d = idle_q + IDLE_ONE;
      end
    end
  end

  always_comb begin
    fail_d     = fail_q;
    lockout_d  = lockout_q;
    lock_tmr_d = lock_tmr_q;
    if (lockout_q) begin
      if (lock_tmr_q == LOCK_ONE) begin
        lockout_d  = 1'b0;
        lock_tmr_d = '0;
      end else begin
        lock_tmr_d = lock_tmr_q - LOCK_ONE;
      end
    end
    if (code_ok) begin
      fail_d = '0;
    end else if (code_bad) begin
      if (fail_inc == FAIL_MAX) begin
        fail_d     = '0;
        lockout_d  = 1'b1;
        lock_tmr_d = LOCK_LOAD;
      end else begin
        fail_d = fail_inc;
      end
    end
    key_ready_d = !lockout_d;
  end

  // A correct code always wins over sensors and timer expiry.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    case (state_q)
      S_DISARMED: begin
        if (code_ok) begin
          state_d = S_EXIT_DELAY;
          dly_d   = EXIT_LOAD;
        end
      end
      S_EXIT_DELAY: begin
        if (code_ok) begin
          state_d = S_DISARMED;
          dly_d   = '0;
        end else if (dly_q == DLY_ONE) begin
          state_d = S_ARMED;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - DLY_ONE;
        end
      end
      S_ARMED: begin
        if (code_ok) begin
          state_d = S_DISARMED;
        end else if (facility_movement_detected) begin
          state_d = S_ALARM;
        end else if (door_movement_detected) begin
          state_d = S_ENTRY_DELAY;
          dly_d   = ENTRY_LOAD;
        end
      end
      S_ENTRY_DELAY: begin
        if (code_ok) begin
          state_d = S_DISARMED;
          dly_d   = '0;
        end else if (facility_movement_detected) begin
          state_d = S_ALARM;
          dly_d   = '0;
        end else if (dly_q == DLY_ONE) begin
          state_d = S_ALARM;
          dly_d   = '0;
        end else begin
          dly_d = dly_q - DLY_ONE;
        end
      end
      S_ALARM: begin
        if (code_ok) begin
          state_d = S_DISARMED;
        end
      end
      default: begin
        state_d = S_DISARMED;
        dly_d   = '0;
      end
    endcase
    armed_d = (state_d == S_ARMED) || (state_d == S_ENTRY_DELAY) || (state_d == S_ALARM);
    led_d   = (state_d != S_DISARMED);
    alert_d = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_DISARMED;
      dly_q       <= '0;
      digits_q    <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      fail_q      <= '0;
      lockout_q   <= 1'b0;
      lock_tmr_q  <= '0;
      key_ready_q <= 1'b0;
      armed_q     <= 1'b0;
      led_q       <= 1'b0;
      alert_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      digits_q    <= digits_d;
      cnt_q       <= cnt_d;
      idle_q      <= idle_d;
      fail_q      <= fail_d;
      lockout_q   <= lockout_d;
      lock_tmr_q  <= lock_tmr_d;
      key_ready_q <= key_ready_d;
      armed_q     <= armed_d;
      led_q       <= led_d;
      alert_q     <= alert_d;
    end
  end

  assign state             = state_q;
  assign key_ready         = key_ready_q;
  assign armed             = armed_q;
  assign led               = led_q;
  assign alert_authorities = alert_q;
  assign lockout           = lockout_q;
  assign fail_count        = fail_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: an elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_alarm_sequencer;

  localparam int EXIT_CYCLES    = 4;
  localparam int ENTRY_CYCLES   = 3;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int DIGIT_TIMEOUT  = 10;
  localparam int GOOD_CODE      = 'h0965;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       door = 1'b0;
  logic       facility = 1'b0;
  logic       key_ready;
  logic [2:0] state;
  logic       armed;
  logic       led;
  logic       alert_authorities;
  logic       lockout;
  logic [1:0] fail_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  alarm_sequencer #(
    .CODE(16'h0965),
    .EXIT_CYCLES(EXIT_CYCLES),
    .ENTRY_CYCLES(ENTRY_CYCLES),
    .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .DIGIT_TIMEOUT(DIGIT_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .door_movement_detected(door),
    .facility_movement_detected(facility),
    .state(state),
    .armed(armed),
    .led(led),
    .alert_authorities(alert_authorities),
    .lockout(lockout),
    .fail_count(fail_count)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: timing expressed as elapsed cycles since the triggering edge.
  int m_cycle = 0;
  int m_state = 0;
  int m_fails = 0;
  int m_lock_start = -1000;
  int m_entered = 0;
  int m_last_acc = 0;
  int m_code = 0;
  int m_next = 0;
  int m_elapsed = 0;
  int m_digits[$];
  bit m_lockout = 1'b0;
  bit m_ready = 1'b0;
  bit m_ok = 1'b0;
  bit m_bad = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_state = 0;
      m_fails = 0;
      m_lockout = 1'b0;
      m_ready = 1'b0;
      m_lock_start = -1000;
      m_entered = m_cycle;
      m_last_acc = m_cycle;
      m_digits.delete();
    end else begin
      m_cycle++;
      m_ok = 1'b0;
      m_bad = 1'b0;
      if (key_valid && m_ready) begin
        m_digits.push_back(int'(key_code));
        m_last_acc = m_cycle;
        if (m_digits.size() == 4) begin
          m_code = m_digits[0] * 4096 + m_digits[1] * 256 + m_digits[2] * 16 + m_digits[3];
          m_ok = (m_code == GOOD_CODE);
          m_bad = !m_ok;
          m_digits.delete();
        end
      end else if (m_digits.size() > 0 && (m_cycle - m_last_acc) == DIGIT_TIMEOUT) begin
        m_digits.delete();
      end
      if (m_ok) m_fails = 0;
      if (m_bad) begin
        m_fails++;
        if (m_fails == MAX_FAILS) begin
          m_fails = 0;
          m_lock_start = m_cycle;
        end
      end
      m_lockout = (m_cycle >= m_lock_start) && (m_cycle < m_lock_start + LOCKOUT_CYCLES);
      m_ready = !m_lockout;
      m_elapsed = m_cycle - m_entered;
      m_next = m_state;
      if (m_ok) begin
        m_next = (m_state == 0) ? 1 : 0;
      end else begin
        case (m_state)
          1: if (m_elapsed == EXIT_CYCLES) m_next = 2;
          2: if (facility) m_next = 4; else if (door) m_next = 3;
          3: if (facility || m_elapsed == ENTRY_CYCLES) m_next = 4;
          default: m_next = m_state;
        endcase
      end
      if (m_next != m_state) m_entered = m_cycle;
      m_state = m_next;
    end
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("model_state", int'(state), m_state);
      checkOutput("model_armed", int'(armed), int'(m_state >= 2));
      checkOutput("model_led", int'(led), int'(m_state != 0));
      checkOutput("model_alert", int'(alert_authorities), int'(m_state == 4));
      checkOutput("model_lockout", int'(lockout), int'(m_lockout));
      checkOutput("model_fail_count", int'(fail_count), m_fails);
      checkOutput("model_key_ready", int'(key_ready), int'(m_ready));
    end
  end

  // Drives one cycle of inputs starting at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [3:0] k, input logic d, input logic f);
    key_valid = v;
    key_code = k;
    door = d;
    facility = f;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic pressCode(input logic [15:0] c);
    applyStimulus(1'b1, c[15:12], 1'b0, 1'b0);
    applyStimulus(1'b1, c[11:8], 1'b0, 1'b0);
    applyStimulus(1'b1, c[7:4], 1'b0, 1'b0);
    applyStimulus(1'b1, c[3:0], 1'b0, 1'b0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_state"}, int'(state), 0);
    checkOutput({tag, "_armed"}, int'(armed), 0);
    checkOutput({tag, "_led"}, int'(led), 0);
    checkOutput({tag, "_alert"}, int'(alert_authorities), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst = 1'b0;
    #1;
    checkIdleOutputs("reset");
    checkOutput("reset_key_ready", int'(key_ready), 0);
    checkOutput("reset_lockout", int'(lockout), 0);
    checkOutput("reset_fail_count", int'(fail_count), 0);
    check_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("release_key_ready", int'(key_ready), 0);
    idleCycles(1);
    checkIdleOutputs("release");
    checkOutput("release_key_ready_next", int'(key_ready), 1);

    $display("[TB] arm sequence");
    pressCode(16'h0965);
    checkOutput("arm_state", int'(state), 1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("exit_door_ignored", int'(state), 1);
    idleCycles(2);
    checkOutput("exit_hold", int'(state), 1);
    idleCycles(1);
    checkOutput("armed_state", int'(state), 2);
    checkOutput("armed_flag", int'(armed), 1);
    checkOutput("armed_led", int'(led), 1);

    $display("[TB] entry without code");
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("entry_state", int'(state), 3);
    idleCycles(2);
    checkOutput("entry_hold", int'(state), 3);
    checkOutput("entry_alert", int'(alert_authorities), 0);
    idleCycles(1);
    checkOutput("entry_expire_state", int'(state), 4);
    checkOutput("entry_expire_alert", int'(alert_authorities), 1);
    pressCode(16'h0965);
    checkIdleOutputs("alarm_cleared");

    $display("[TB] entry with code on expiry edge");
    pressCode(16'h0965);
    idleCycles(4);
    checkOutput("rearm_state", int'(state), 2);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
    checkOutput("partial_code_state", int'(state), 2);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("entry_b_hold", int'(state), 3);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    checkIdleOutputs("entry_b_disarm");

    $display("[TB] facility breach");
    pressCode(16'h0965);
    idleCycles(4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    checkOutput("breach_state", int'(state), 4);
    checkOutput("breach_alert", int'(alert_authorities), 1);
    idleCycles(5);
    checkOutput("breach_latched", int'(alert_authorities), 1);
    pressCode(16'h0965);
    checkIdleOutputs("breach_cleared");

    $display("[TB] lockout");
    pressCode(16'h1111);
    checkOutput("fail_1", int'(fail_count), 1);
    checkOutput("fail_1_state", int'(state), 0);
    pressCode(16'h1111);
    checkOutput("fail_2", int'(fail_count), 2);
    pressCode(16'h1111);
    checkOutput("lock_on", int'(lockout), 1);
    checkOutput("lock_fail_clear", int'(fail_count), 0);
    checkOutput("lock_key_ready", int'(key_ready), 0);
    repeat (LOCKOUT_CYCLES - 1) applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
    checkOutput("lock_last_cycle", int'(lockout), 1);
    checkOutput("lock_last_ready", int'(key_ready), 0);
    idleCycles(1);
    checkOutput("lock_off", int'(lockout), 0);
    checkOutput("lock_off_ready", int'(key_ready), 1);
    pressCode(16'h0965);
    checkOutput("post_lock_arm", int'(state), 1);
    pressCode(16'h1111);
    checkOutput("wrong_code_no_disarm", int'(state), 2);
    checkOutput("wrong_then_fail", int'(fail_count), 1);
    pressCode(16'h0965);
    checkOutput("right_clears_fail", int'(fail_count), 0);
    checkOutput("right_disarms", int'(state), 0);

    $display("[TB] digit timeout");
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h9, 1'b0, 1'b0);
    idleCycles(DIGIT_TIMEOUT);
    pressCode(16'h0965);
    checkOutput("timeout_then_arm", int'(state), 1);
    checkOutput("timeout_no_fail", int'(fail_count), 0);

    $display("[TB] async reset in entry delay");
    idleCycles(4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("pre_reset_state", int'(state), 3);
    key_valid = 1'b0;
    door = 1'b0;
    #1 rst = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    checkOutput("async_reset_ready", int'(key_ready), 0);
    checkOutput("async_reset_lockout", int'(lockout), 0);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(1);
    checkOutput("after_reset_ready", int'(key_ready), 1);
    checkOutput("after_reset_state", int'(state), 0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Arm/disarm sequencing controller for the facility security keypad. It consumes decoded key events from the keypad scanner through a valid/ready handshake and assembles 4-digit codes. It runs the exit-delay / armed / entry-delay / alarm state machine against the door and facility sensors, and enforces a lockout after repeated wrong codes. It drives the status LED and the authorities alert line.

Parameters:
CODE, 16'h0965, expected code as four 4-bit matrix codes, first digit in [15:12] (1,8,6,5 = 0000,1001,0110,0101)
EXIT_CYCLES, 16, cycles spent in EXIT_DELAY before ARMED (>=1)
ENTRY_CYCLES, 16, cycles spent in ENTRY_DELAY before ALARM (>=1)
MAX_FAILS, 3, consecutive wrong codes that trigger lockout (>=1)
LOCKOUT_CYCLES, 32, lockout duration in cycles (>=1)
DIGIT_TIMEOUT, 64, idle cycles after which a partial entry is discarded (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
key_valid  in  1  scanner presents a key event
key_code  in  4  matrix code {row[1:0],col[1:0]}, valid with key_valid
key_ready  out  1  sequencer accepts key events
door_movement_detected  in  1  door sensor, level
facility_movement_detected  in  1  interior sensor, level
state  out  3  FSM state: 0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 ENTRY_DELAY, 4 ALARM
armed  out  1  state is ARMED, ENTRY_DELAY or ALARM
led  out  1  state != DISARMED
alert_authorities  out  1  state == ALARM
lockout  out  1  keypad locked out
fail_count  out  $clog2(MAX_FAILS+1)  consecutive wrong codes

Behaviour:
- Reset (rst=0, async): state=DISARMED, armed=0, led=0, alert_authorities=0, lockout=0, fail_count=0, key_ready=0. Digit buffer, digit count and all timers are cleared. The cycle after rst deasserts, key_ready=1.
- All outputs are registered. key_ready = !lockout.
- Handshake: a key is accepted on an edge where key_valid && key_ready. Each accepted cycle consumes one digit. The scanner must hold key_valid for one cycle per press.
- Digit buffer: accepted digits shift in first-to-MSB, digit count 0..3.
- On the edge accepting the 4th digit, the 3 stored digits and the incoming digit are compared against CODE. The buffer and count clear on that edge.
  - Match ("code_ok"): fail_count -> 0.
  - Mismatch: fail_count+1. If the result equals MAX_FAILS, lockout -> 1, the lockout timer loads LOCKOUT_CYCLES, and fail_count -> 0.
- Lockout: the timer decrements each cycle. lockout stays 1 for exactly LOCKOUT_CYCLES cycles, then clears. The FSM, sensors and delay timers keep running during lockout.
- Digit timeout: with count 1..3, the idle counter increments each cycle with no accepted key. After DIGIT_TIMEOUT idle cycles, buffer and count clear with no fail counted. Any accepted key resets the idle counter.
- FSM transitions, evaluated each edge (code_ok has top priority everywhere):
  - DISARMED: code_ok -> EXIT_DELAY, delay timer = EXIT_CYCLES. Sensors are ignored.
  - EXIT_DELAY: code_ok -> DISARMED. Otherwise the timer decrements; on reaching 0 -> ARMED. Sensors are ignored. The state is held for exactly EXIT_CYCLES cycles.
  - ARMED: code_ok -> DISARMED. Else facility -> ALARM. Else door -> ENTRY_DELAY, timer = ENTRY_CYCLES.
  - ENTRY_DELAY: code_ok -> DISARMED. Else facility -> ALARM. Else timer decrements; on reaching 0 -> ALARM. The door sensor is ignored.
  - ALARM: code_ok -> DISARMED, otherwise hold (latched alarm).
- Simultaneous events:
  - door+facility in ARMED -> ALARM.
  - Timer expiry and code_ok on the same edge -> DISARMED.
  - A wrong code never changes FSM state.
- State encodings 5..7 are illegal and recover to DISARMED on the next edge.

Test Plan:
Bench parameters: EXIT_CYCLES=4, ENTRY_CYCLES=3, MAX_FAILS=3, LOCKOUT_CYCLES=8, DIGIT_TIMEOUT=10.
1. Reset and hold: rst low, then high, with no keys -> state=0, led=0, armed=0, alert_authorities=0, key_ready=1 from the cycle after release.
2. Arm: keys 0x0,0x9,0x6,0x5 -> state=1 on the 4th accepted edge, 4 cycles later state=2, armed=1, led=1. A door pulse during EXIT_DELAY is ignored.
3. Entry flow: from ARMED, door=1 -> state=3. Case (a): no code -> state=4 and alert_authorities=1 after 3 cycles. Case (b): correct code within 3 cycles -> state=0, alert_authorities stays 0.
4. Facility breach: ARMED, facility=1 -> state=4 next edge. Hold sensors low -> alert_authorities stays 1 until the correct code, then state=0 and all outputs 0.
5. Lockout: 3 wrong codes (0x1,0x1,0x1,0x1) -> fail_count goes 1, 2, then lockout=1 with fail_count=0. key_ready=0 for 8 cycles, and key_valid pulses during that window are not accepted. After expiry, the correct code arms normally. A wrong code followed by the correct code -> fail_count=0.
6. Timeout and reset: 2 digits, then 10 idle cycles, then the full correct code -> exactly 4 further digits arm the system. Separately, assert rst mid-ENTRY_DELAY -> all outputs return to reset values immediately (asynchronously).
